// File: rtl/matrix_mul_seq_if.sv
// Stream bundle for matrix_mul_seq: serial element input (A then B) and
// row-major result output with a last marker.
interface matrix_mul_seq_if #(
  parameter int DATA_W = 4,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matrix_mul_seq.sv
// 2x2 matrix multiplier sharing one MAC over eight compute steps (load -> compute -> output).
// Define MATRIX_MUL_SEQ_SAT_EN to saturate out-of-range results instead of truncating them.
module matrix_mul_seq #(
  parameter int DATA_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  matrix_mul_seq_if.slave bus,
  output logic            busy,
  output logic            overflow
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + 1;
  localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        load_cnt_q, load_cnt_d;
  logic [2:0]        step_q, step_d;
  logic [1:0]        out_cnt_q, out_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] elem_q [8];
  logic [DATA_W-1:0] elem_d [8];
  logic [OUT_W-1:0]  c_q [4];
  logic [OUT_W-1:0]  c_d [4];

  logic              in_ready_w;
  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] b_op;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;
  logic [OUT_W-1:0]  c_wr;

  assign in_ready_w = (state_q == ST_LOAD) && !rst;

  // Step s: i = s[2], j = s[1], k = s[0]; A[i][k] is slot 2i+k, B[k][j] is slot 4+2k+j.
  assign a_op = elem_q[{1'b0, step_q[2], step_q[0]}];
  assign b_op = elem_q[{1'b1, step_q[0], step_q[1]}];
  assign prod = {{DATA_W{1'b0}}, a_op} * {{DATA_W{1'b0}}, b_op};
  assign sum  = (step_q[0] ? acc_q : {ACC_W{1'b0}}) + {1'b0, prod};

  assign sum_ovf = CMP_W'(sum) > CMP_W'(OUT_MAX);

  always_comb begin
`ifdef MATRIX_MUL_SEQ_SAT_EN
    c_wr = sum_ovf ? OUT_MAX : OUT_W'(sum);
`else
    c_wr = OUT_W'(sum);
`endif
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    step_d     = step_q;
    out_cnt_d  = out_cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    elem_d     = elem_q;
    c_d        = c_q;

    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid && in_ready_w) begin
          elem_d[load_cnt_q] = bus.in_data;
          load_cnt_d         = load_cnt_q + 3'd1;
          if (load_cnt_q == 3'd0) begin
            ovf_d = 1'b0;
          end
          if (load_cnt_q == 3'd7) begin
            state_d = ST_COMPUTE;
            step_d  = 3'd0;
          end
        end
      end

      ST_COMPUTE: begin
        acc_d  = sum;
        step_d = step_q + 3'd1;
        if (step_q[0]) begin
          c_d[step_q[2:1]] = c_wr;
          if (sum_ovf) begin
            ovf_d = 1'b1;
          end
        end
        if (step_q == 3'd7) begin
          state_d   = ST_OUTPUT;
          out_cnt_d = 2'd0;
        end
      end

      ST_OUTPUT: begin
        if (bus.out_ready) begin
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == 2'd3) begin
            state_d    = ST_LOAD;
            load_cnt_d = 3'd0;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= 3'd0;
      step_q     <= 3'd0;
      out_cnt_q  <= 2'd0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        elem_q[n] <= '0;
      end
      for (int n = 0; n < 4; n++) begin
        c_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      step_q     <= step_d;
      out_cnt_q  <= out_cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      for (int n = 0; n < 8; n++) begin
        elem_q[n] <= elem_d[n];
      end
      for (int n = 0; n < 4; n++) begin
        c_q[n] <= c_d[n];
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_OUTPUT);
  assign bus.out_data  = (state_q == ST_OUTPUT) ? c_q[out_cnt_q] : '0;
  assign bus.out_last  = (state_q == ST_OUTPUT) && (out_cnt_q == 2'd3);
  assign busy          = (state_q != ST_LOAD) || (load_cnt_q != 3'd0);
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Bench for matrix_mul_seq: vector table plus random products checked through an
// output scoreboard, with hand-written reset-abort and protocol-guard sequences.
module tb_matrix_mul_seq;

  localparam int DATA_W = 4;
  localparam int OUT_W  = 8;
`ifdef MATRIX_MUL_SEQ_SAT_EN
  localparam int C450 = 255;
  localparam int C256 = 255;
`else
  localparam int C450 = 194;
  localparam int C256 = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic overflow;

  matrix_mul_seq_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  matrix_mul_seq #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][3:0] e;
    logic [3:0][7:0] c;
    logic            ovf;
    logic [1:0]      gap;
    logic            tog;
    logic            hold;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic held = 1'b0;
  logic [7:0] held_d;
  logic held_l;
  logic rdy_tog = 1'b0;
  bit   rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input int a00, a01, a10, a11, b00, b01, b10, b11,
                               input int c00, c01, c10, c11,
                               input bit ovf, input int gap, input bit tog, input bit hold);
    vec_t v;
    v      = '0;
    v.e[0] = 4'(a00); v.e[1] = 4'(a01); v.e[2] = 4'(a10); v.e[3] = 4'(a11);
    v.e[4] = 4'(b00); v.e[5] = 4'(b01); v.e[6] = 4'(b10); v.e[7] = 4'(b11);
    v.c[0] = 8'(c00); v.c[1] = 8'(c01); v.c[2] = 8'(c10); v.c[3] = 8'(c11);
    v.ovf  = ovf;
    v.gap  = 2'(gap);
    v.tog  = tog;
    v.hold = hold;
    return v;
  endfunction

  // Reference product: C[i][j] = A[i][0]*B[0][j] + A[i][1]*B[1][j].
  function automatic vec_t mk_rand();
    vec_t v;
    int   s;
    v = '0;
    for (int n = 0; n < 8; n++) v.e[n] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = int'(v.e[i*2]) * int'(v.e[4+j]) + int'(v.e[i*2+1]) * int'(v.e[6+j]);
        if (s > 255) begin
          v.ovf = 1'b1;
`ifdef MATRIX_MUL_SEQ_SAT_EN
          s = 255;
`else
          s = s % 256;
`endif
        end
        v.c[i*2+j] = 8'(s);
      end
    end
    v.gap = 2'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        held = 1'b0;
      end else if (bus.out_valid) begin
        if (held) begin
          chk("hold_data", int'(bus.out_data), int'(held_d));
          chk("hold_last", int'(bus.out_last), int'(held_l));
        end
        if (bus.out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got data %0d, want no output (t=%0t)", bus.out_data, $time);
          end else begin
            mon_e = exp_q.pop_front();
            $display("out: data=%0d last=%0b want data=%0d last=%0b", bus.out_data, bus.out_last, mon_e.d, mon_e.last);
            chk("out_data", int'(bus.out_data), int'(mon_e.d));
            chk("out_last", int'(bus.out_last), int'(mon_e.last));
          end
        end else begin
          held   = 1'b1;
          held_d = bus.out_data;
          held_l = bus.out_last;
        end
      end else begin
        held = 1'b0;
      end
    end
  endtask

  task automatic rdy_loop();
    int pidx = 0;
    forever begin
      @(negedge clk);
      if (rdy_tog) begin
        bus.out_ready = rdy_pat[pidx];
        pidx          = (pidx + 1) % 4;
      end else begin
        bus.out_ready = 1'b1;
        pidx          = 0;
      end
    end
  endtask

  task automatic put(input logic [3:0] d);
    int n = 0;
    chk("out_valid_in_load", int'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, want 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d results pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t x;
    for (int r = 0; r < 4; r++) begin
      x.d    = v.c[r];
      x.last = (r == 3);
      exp_q.push_back(x);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    push_exp(v);
    rdy_tog = v.tog;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (int'(v.gap)) @(negedge clk);
      put(v.e[i]);
      if (i == 0) chk("ovf_clear_first", int'(overflow), 0);
    end
    if (v.hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'hF;
    end
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (n == 3) chk("in_ready_compute", int'(bus.in_ready), 0);
      @(negedge clk);
      n++;
    end
    chk("latency", n, 8);
    wait_drain();
    bus.in_valid = 1'b0;
    rdy_tog      = 1'b0;
    chk("ovf_sticky", int'(overflow), int'(v.ovf));
    chk("idle_in_ready", int'(bus.in_ready), 1);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    vec_t v;
    fork
      mon_loop();
      rdy_loop();
    join_none

    vecs[0] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 0, 0);
    vecs[1] = mkv(15, 15, 15, 15, 15, 15, 15, 15, C450, C450, C450, C450, 1, 0, 0, 0);
    vecs[2] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 0, 0);
    vecs[3] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 3, 0, 0);
    vecs[4] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 1, 0);
    vecs[5] = mkv(0, 1, 1, 0, 9, 8, 7, 6, 7, 6, 9, 8, 0, 0, 0, 0);
    vecs[6] = mkv(15, 15, 15, 15, 15, 15, 2, 2, 255, 255, 255, 255, 0, 0, 0, 0);
    vecs[7] = mkv(12, 10, 12, 10, 13, 13, 10, 10, C256, C256, C256, C256, 1, 0, 0, 0);
    vecs[8] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 0, 1);
    vecs[9] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 0, 0);

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    for (int t = 0; t < 10; t++) begin
      $display("vec %0d: gap=%0d tog=%0b hold=%0b", t, vecs[t].gap, vecs[t].tog, vecs[t].hold);
      run_vec(vecs[t]);
    end

    for (int t = 0; t < 4; t++) begin
      v = mk_rand();
      $display("rand %0d: elems=%h", t, v.e);
      run_vec(v);
    end

    // Abort an overflowing matrix at compute step 3; nothing of it may surface.
    v = mkv(15, 15, 15, 15, 15, 15, 15, 15, C450, C450, C450, C450, 1, 0, 0, 0);
    push_exp(v);
    for (int i = 0; i < 8; i++) put(v.e[i]);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_data", int'(bus.out_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overflow", int'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", int'(bus.in_ready), 1);
    run_vec(mkv(2, 0, 0, 2, 3, 4, 5, 6, 6, 8, 10, 12, 0, 0, 0, 0));

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by %0t, want finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
